// File: rtl/fifo_rd_stream.sv
// Read-side stream stage of the async FIFO: 2-entry prefetch buffer turning rempty/rinc/rdata
// into valid/ready. Define FIFO_RD_MEM_REG_EN when the FIFO memory has a registered read port.
module fifo_rd_stream #(
  parameter int unsigned DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          occupancy
);

  logic [DATASIZE-1:0] slot_q [2];
  logic                head_q;
  logic                tail_q;
  logic [1:0]          count_q;
  logic                pop;
  logic                capture;
  logic                inflight;
  logic [2:0]          level;
  logic [2:0]          count_sum;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = slot_q[head_q];
  assign occupancy = count_q;

  // Words held plus words already requested, after this cycle's pop; 3 bits avoid wrap.
  assign level = {1'b0, count_q} + {2'b0, inflight} - {2'b0, pop};
  assign rinc  = rrst_n & ~rempty & (level < 3'd2);

`ifdef FIFO_RD_MEM_REG_EN
  logic inflight_q;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rinc;
    end
  end

  assign inflight = inflight_q;
  assign capture  = inflight_q;
`else
  assign inflight = 1'b0;
  assign capture  = rinc;
`endif

  assign count_sum = {1'b0, count_q} + {2'b0, capture} - {2'b0, pop};

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_sum[1:0];
      if (pop) begin
        head_q <= ~head_q;
      end
      if (capture) begin
        tail_q <= ~tail_q;
      end
    end
  end

  // Slot contents are deliberately not reset.
  always_ff @(posedge rclk) begin
    if (rrst_n && capture) begin
      slot_q[tail_q] <= rdata;
    end
  end

  count_le_two: assert property (@(posedge rclk) disable iff (!rrst_n) count_sum <= 3'd2);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read side (pointer, empty, memory).
module tb_fifo_rd_stream;

`ifdef FIFO_RD_MEM_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] occupancy;

  logic [7:0] mem [0:1023];
  int         rptr = 0;
  int         wptr = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int pop_idx, rinc_cnt, cyc, first_rinc, first_valid, first_pop, last_pop, max_occ;
  int first_pop_data;
  logic       prev_valid, prev_ready;
  logic [7:0] prev_data;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATASIZE(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // Behavioural read side: pointer advance and empty flag settle at the same edge.
  always @(posedge rclk) begin
    if (!rrst_n) rptr <= 0;
    else if (rinc) rptr <= rptr + 1;
  end
  assign rempty = (rptr == wptr);

`ifdef FIFO_RD_MEM_REG_EN
  logic [7:0] rdata_q;
  always @(posedge rclk) if (rinc) rdata_q <= mem[rptr];
  assign rdata = rdata_q;
`else
  assign rdata = mem[rptr];
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    pop_idx = 0; rinc_cnt = 0; cyc = 0; max_occ = 0;
    first_rinc = -1; first_valid = -1; first_pop = -1; last_pop = -1; first_pop_data = -1;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
  endtask

  // Called at a falling edge: drive ready, sample, and advance to the next falling edge.
  task automatic cycle(input logic rdy);
    out_ready = rdy;
    #1;
    if (prev_valid && !prev_ready) begin
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_data", {24'd0, out_data}, {24'd0, prev_data});
    end
    if (rinc) begin
      rinc_cnt++;
      if (first_rinc < 0) first_rinc = cyc;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    if (out_valid && out_ready) begin
      if (pop_idx >= wptr) check_eq("extra_pop", pop_idx, wptr);
      else check_eq("pop_data", {24'd0, out_data}, {24'd0, mem[pop_idx]});
      if (first_pop < 0) begin
        first_pop = cyc;
        first_pop_data = int'(out_data);
      end
      last_pop = cyc;
      pop_idx++;
    end
    prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
    cyc++;
    @(negedge rclk);
  endtask

  // Holds reset for two edges; checks cleared state after the first. Leaves rrst_n low.
  task automatic do_reset();
    rrst_n = 1'b0; out_ready = 1'b0; wptr = 0;
    @(negedge rclk);
    #1;
    check_eq("rst_occ", {30'd0, occupancy}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_rinc", {31'd0, rinc}, 32'd0);
    @(negedge rclk);
    clear_stats();
  endtask

  initial begin
    rrst_n = 1'b0; out_ready = 1'b0;
    clear_stats();
    // Reset with a non-empty FIFO: rinc must stay low throughout.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    wptr = 16;
    #1;
    check_eq("rst_rinc_comb", {31'd0, rinc}, 32'd0);
    repeat (2) begin
      @(negedge rclk);
      #1;
      check_eq("rst_rinc_hold", {31'd0, rinc}, 32'd0);
      check_eq("rst_valid0", {31'd0, out_valid}, 32'd0);
      check_eq("rst_occ0", {30'd0, occupancy}, 32'd0);
    end

    // Streaming 0x01..0x10 with ready held high.
    rrst_n = 1'b1;
    for (int n = 0; n < 60 && pop_idx < 16; n++) cycle(1'b1);
    check_eq("stream_count", pop_idx, 16);
    check_eq("stream_latency", first_valid - first_rinc, Lat);
    check_eq("stream_no_bubble", last_pop - first_pop, 15);
    check_eq("stream_first", first_pop_data, 32'h01);

    // Backpressure: 10 stalled cycles, then drain 0xA0..0xA7.
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'hA0 + i);
    wptr = 8;
    rrst_n = 1'b1;
    repeat (10) cycle(1'b0);
    check_eq("bp_rinc_pulses", rinc_cnt, 2);
    check_eq("bp_occ", {30'd0, occupancy}, 32'd2);
    check_eq("bp_head", {24'd0, out_data}, 32'hA0);
    check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
    for (int n = 0; n < 40 && pop_idx < 8; n++) cycle(1'b1);
    check_eq("bp_drained", pop_idx, 8);

    // Random ready over 1000 words.
    do_reset();
    for (int i = 0; i < 1000; i++) mem[i] = 8'($urandom_range(0, 255));
    wptr = 1000;
    rrst_n = 1'b1;
    for (int n = 0; n < 6000 && pop_idx < 1000; n++) cycle(1'($urandom_range(0, 1)));
    check_eq("rand_count", pop_idx, 1000);
    check_eq("rand_max_occ_le2", {31'd0, (max_occ <= 2)}, 32'd1);

    // Empty boundary: a single word.
    do_reset();
    mem[0] = 8'h5A;
    wptr = 1;
    rrst_n = 1'b1;
    repeat (8) cycle(1'b1);
    check_eq("empty_rinc_pulses", rinc_cnt, 1);
    check_eq("empty_pops", pop_idx, 1);
    check_eq("empty_word", first_pop_data, 32'h5A);
    out_ready = 1'b1;
    #1;
    check_eq("empty_valid0", {31'd0, out_valid}, 32'd0);
    check_eq("empty_rinc0", {31'd0, rinc}, 32'd0);
    @(negedge rclk);

    // Mid-stream reset with a full buffer.
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h30 + i);
    wptr = 8;
    rrst_n = 1'b1;
    repeat (5) cycle(1'b0);
    check_eq("mid_occ2", {30'd0, occupancy}, 32'd2);
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'(8'hC3 + i);
    wptr = 4;
    rrst_n = 1'b1;
    for (int n = 0; n < 30 && pop_idx < 4; n++) cycle(1'b1);
    check_eq("mid_first_after_rst", first_pop_data, 32'hC3);
    check_eq("mid_count", pop_idx, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
